// File: rtl/multiplier_pkg.sv
// Shared types and elaboration helpers for the iterative shift-add multiplier.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MULTIPLY,
        DONE
    } mult_fsm_t;

    // Widest operand abs_value can handle.
    localparam int ABS_MAX_WIDTH = 64;

    function automatic int iterations(input int data_width, input int rows_per_cycle);
        return data_width / rows_per_cycle;
    endfunction

    function automatic int counter_width(input int iters);
        return (iters > 1) ? $clog2(iters) : 1;
    endfunction

    function automatic logic [ABS_MAX_WIDTH-1:0] abs_value(
        input logic [ABS_MAX_WIDTH-1:0] value,
        input int                       width,
        input logic                     is_signed
    );
        logic [ABS_MAX_WIDTH-1:0] mask;
        mask = {ABS_MAX_WIDTH{1'b1}} >> (ABS_MAX_WIDTH - width);
        if (is_signed && value[width-1])
            return (~value + ABS_MAX_WIDTH'(1)) & mask;
        return value & mask;
    endfunction

endpackage

// File: rtl/multiplier_row_stage.sv
// One product row: conditionally adds the multiplicand, retires the LSB and
// hands the carry-extended partial sum to the next row.
module multiplier_row_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_partial_sum,
    input  logic [DATA_WIDTH-1:0] i_multiplicand,
    input  logic                  i_multiplier_bit,
    output logic                  o_product_bit,
    output logic [DATA_WIDTH-1:0] o_partial_sum
);

    logic [DATA_WIDTH:0] w_sum;

    assign w_sum         = {1'b0, i_partial_sum} + (i_multiplier_bit ? {1'b0, i_multiplicand} : '0);
    assign o_product_bit = w_sum[0];
    assign o_partial_sum = w_sum[DATA_WIDTH:1];

endmodule

// File: rtl/long_multiplier_iterative.sv
// Iterative sign-magnitude multiplier: ROWS_PER_CYCLE chained rows per clock,
// valid/ready on both sides, one operation in flight.
module long_multiplier_iterative
    import multiplier_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ROWS_PER_CYCLE = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [DATA_WIDTH-1:0]   operand_A_i,
    input  logic [DATA_WIDTH-1:0]   operand_B_i,
    input  logic                    signed_i,
    output logic [2*DATA_WIDTH-1:0] product_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    localparam int W          = DATA_WIDTH;
    localparam int R          = ROWS_PER_CYCLE;
    localparam int ITERATIONS = iterations(W, R);
    localparam int CNT_W      = counter_width(ITERATIONS);

    mult_fsm_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]   r_mag_a;
    logic [W-1:0]   r_mag_b;
    logic           r_neg;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_product;
    logic           r_valid;
    logic           r_ready;

    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic [W-1:0]   w_psum [0:R];
    logic [R-1:0]   w_bits;
    logic [W-1:0]   w_lo_final;
    logic [2*W-1:0] w_acc_final;
    logic [2*W-1:0] w_product_final;

    assign w_mag_a = W'(abs_value(ABS_MAX_WIDTH'(operand_A_i), W, signed_i));
    assign w_mag_b = W'(abs_value(ABS_MAX_WIDTH'(operand_B_i), W, signed_i));

    // Upper half of the accumulator is the running partial sum.
    assign w_psum[0] = r_acc[2*W-1:W];

    for (genvar k = 0; k < R; k++) begin : g_rows
        multiplier_row_stage #(.DATA_WIDTH(W)) u_row (
            .i_partial_sum   (w_psum[k]),
            .i_multiplicand  (r_mag_a),
            .i_multiplier_bit(r_mag_b[k]),
            .o_product_bit   (w_bits[k]),
            .o_partial_sum   (w_psum[k+1])
        );
    end

    // The final iteration retires the top R product bits of the low half.
    always_comb begin
        w_lo_final             = r_acc[W-1:0];
        w_lo_final[W-1 -: R]   = w_bits;
    end

    assign w_acc_final     = {w_psum[R], w_lo_final};
    assign w_product_final = r_neg ? -w_acc_final : w_acc_final;

    // NOTE: all state here uses non-blocking assignments so every register
    // sees pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_product <= '0;
            r_valid   <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_mag_a <= w_mag_a;
                        r_mag_b <= w_mag_b;
                        r_neg   <= signed_i & (operand_A_i[W-1] ^ operand_B_i[W-1]);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= MULTIPLY;
                    end
                end
                MULTIPLY: begin
                    r_acc[2*W-1:W]        <= w_psum[R];
                    r_acc[r_cnt*R +: R]   <= w_bits;
                    r_mag_b               <= r_mag_b >> R;
                    r_cnt                 <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(ITERATIONS - 1)) begin
                        r_product <= w_product_final;
                        r_valid   <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o   = r_ready;
    assign valid_o   = r_valid;
    assign product_o = r_product;

endmodule

// File: tb/tb_long_multiplier_iterative.sv
// Directed checks on an 8-bit/2-row instance plus reference-model sweep on the
// default 32-bit/4-row instance.
module tb_long_multiplier_iterative;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // 8-bit, 2 rows per cycle: latency 5, period 6
    logic        a_valid_i, a_ready_o, a_signed, a_valid_o, a_ready_i;
    logic [7:0]  a_A, a_B;
    logic [15:0] a_product;

    // default 32-bit, 4 rows per cycle: latency 9
    logic        b_valid_i, b_ready_o, b_signed, b_valid_o, b_ready_i;
    logic [31:0] b_A, b_B;
    logic [63:0] b_product;

    long_multiplier_iterative #(.DATA_WIDTH(8), .ROWS_PER_CYCLE(2)) dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(a_valid_i), .ready_o(a_ready_o),
        .operand_A_i(a_A), .operand_B_i(a_B), .signed_i(a_signed),
        .product_o(a_product), .valid_o(a_valid_o), .ready_i(a_ready_i)
    );

    long_multiplier_iterative dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(b_valid_i), .ready_o(b_ready_o),
        .operand_A_i(b_A), .operand_B_i(b_B), .signed_i(b_signed),
        .product_o(b_product), .valid_o(b_valid_o), .ready_i(b_ready_i)
    );

    // Called at posedge+1; returns at posedge+1 of the first cycle valid_o is high.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [15:0] p, output int lat);
        int n = 0;
        while (a_ready_o !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        a_A = a; a_B = b; a_signed = s; a_valid_i = 1'b1;
        @(posedge clk); #1;
        a_valid_i = 1'b0;
        lat = 1;
        while (a_valid_o !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
        p = a_product;
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] p, output int lat);
        int n = 0;
        while (b_ready_o !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        b_A = a; b_B = b; b_signed = s; b_valid_i = 1'b1;
        @(posedge clk); #1;
        b_valid_i = 1'b0;
        lat = 1;
        while (b_valid_o !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
        p = b_product;
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({a_ready_o, a_valid_o, a_product} !== {1'b1, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL reset8: ready/valid/product got %b/%b/%h want 1/0/0000", a_ready_o, a_valid_o, a_product);
        end
        n_cmp++;
        if ({b_ready_o, b_valid_o, b_product} !== {1'b1, 1'b0, 64'h0}) begin
            n_bad++;
            $display("FAIL reset32: ready/valid/product got %b/%b/%h want 1/0/0", b_ready_o, b_valid_o, b_product);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_max;
        logic [15:0] p;
        int lat;
        op8(8'hFF, 8'hFF, 1'b0, p, lat);
        n_cmp++;
        if (lat !== 5) begin n_bad++; $display("FAIL ff_latency: got %0d want 5", lat); end
        n_cmp++;
        if (p !== 16'hFE01) begin n_bad++; $display("FAIL ff_product: got %h want fe01", p); end
        @(posedge clk); #1;
        n_cmp++;
        if ({a_valid_o, a_ready_o} !== 2'b01) begin
            n_bad++;
            $display("FAIL ff_single_valid: valid/ready got %b/%b want 0/1", a_valid_o, a_ready_o);
        end
    endtask

    task automatic test_signed;
        logic [15:0] p;
        int lat;
        op8(8'h80, 8'h80, 1'b1, p, lat);
        n_cmp++;
        if (p !== 16'h4000 || lat !== 5) begin n_bad++; $display("FAIL min_x_min: got %h lat %0d want 4000 lat 5", p, lat); end
        op8(8'h80, 8'h7F, 1'b1, p, lat);
        n_cmp++;
        if (p !== 16'hC080 || lat !== 5) begin n_bad++; $display("FAIL min_x_max: got %h lat %0d want c080 lat 5", p, lat); end
        op8(8'h07, 8'hFD, 1'b1, p, lat);
        n_cmp++;
        if (p !== 16'hFFEB) begin n_bad++; $display("FAIL s7_x_m3: got %h want ffeb", p); end
        op8(8'hF9, 8'h03, 1'b0, p, lat);
        n_cmp++;
        if (p !== 16'h02EB) begin n_bad++; $display("FAIL u249_x_3: got %h want 02eb", p); end
    endtask

    task automatic test_back_to_back;
        int accepts[3];
        int na = 0;
        int n = 0;
        logic [15:0] first_p = 16'h0;
        logic got_p = 1'b0;
        while (a_ready_o !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        a_A = 8'd5; a_B = 8'd6; a_signed = 1'b0; a_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (a_ready_o === 1'b1 && na < 3) begin accepts[na] = i; na++; end
            if (a_valid_o === 1'b1 && !got_p) begin first_p = a_product; got_p = 1'b1; end
            @(posedge clk); #1;
        end
        a_valid_i = 1'b0;
        n_cmp++;
        if (na < 2 || accepts[1] - accepts[0] != 6) begin
            n_bad++;
            $display("FAIL b2b_period: accepts seen %0d, spacing %0d want 6", na, (na < 2) ? 0 : accepts[1] - accepts[0]);
        end
        n_cmp++;
        if (first_p !== 16'h001E) begin n_bad++; $display("FAIL b2b_product: got %h want 001e", first_p); end
        n = 0;
        while (!(a_ready_o === 1'b1 && a_valid_o === 1'b0) && n < 50) begin @(posedge clk); #1; n++; end
    endtask

    task automatic test_backpressure;
        logic [15:0] p;
        int lat;
        logic seen;
        a_ready_i = 1'b0;
        op8(8'd13, 8'd11, 1'b0, p, lat);
        n_cmp++;
        if (p !== 16'h008F || lat !== 5) begin n_bad++; $display("FAIL bp_product: got %h lat %0d want 008f lat 5", p, lat); end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin a_A = 8'd1; a_B = 8'd1; a_valid_i = 1'b1; end
            if (i == 4) a_valid_i = 1'b0;
            n_cmp++;
            if ({a_valid_o, a_ready_o, a_product} !== {1'b1, 1'b0, 16'h008F}) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d: valid/ready/product got %b/%b/%h want 1/0/008f", i, a_valid_o, a_ready_o, a_product);
            end
            @(posedge clk); #1;
        end
        a_ready_i = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({a_valid_o, a_ready_o} !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_release: valid/ready got %b/%b want 0/1", a_valid_o, a_ready_o);
        end
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (a_valid_o !== 1'b0) seen = 1'b1; end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL bp_ignored_valid: got spurious valid_o, want none"); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] p;
        int lat;
        logic seen;
        a_A = 8'd100; a_B = 8'd100; a_signed = 1'b0; a_valid_i = 1'b1;
        @(posedge clk); #1;
        a_valid_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({a_ready_o, a_valid_o, a_product} !== {1'b1, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL mid_reset: ready/valid/product got %b/%b/%h want 1/0/0000", a_ready_o, a_valid_o, a_product);
        end
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (a_valid_o !== 1'b0) seen = 1'b1; end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_reset_discard: got valid_o for discarded op"); end
        op8(8'd2, 8'd3, 1'b0, p, lat);
        n_cmp++;
        if (p !== 16'h0006 || lat !== 5) begin n_bad++; $display("FAIL after_reset: got %h lat %0d want 0006 lat 5", p, lat); end
    endtask

    task automatic test_wide_model;
        logic [31:0] corners[5];
        logic [63:0] p, exp_p;
        logic [31:0] a, b;
        logic s;
        int lat;
        corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
        for (int n = 0; n < 1050; n++) begin
            if (n < 50) begin
                a = corners[n % 5]; b = corners[(n / 5) % 5]; s = logic'(n / 25);
            end else begin
                a = $urandom; b = $urandom; s = logic'($urandom_range(0, 1));
            end
            exp_p = ref_mul(a, b, s);
            op32(a, b, s, p, lat);
            n_cmp++;
            if (p !== exp_p) begin
                n_bad++;
                $display("FAIL wide_product %h*%h s=%b: got %h want %h", a, b, s, p, exp_p);
            end
            n_cmp++;
            if (lat !== 9) begin n_bad++; $display("FAIL wide_latency %h*%h: got %0d want 9", a, b, lat); end
        end
    endtask

    initial begin
        rst = 1'b1;
        a_valid_i = 1'b0; a_A = '0; a_B = '0; a_signed = 1'b0; a_ready_i = 1'b1;
        b_valid_i = 1'b0; b_A = '0; b_B = '0; b_signed = 1'b0; b_ready_i = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wide_model();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
